// File: rtl/aes_serial_host.sv
// Host-side initiator for a byte-serial AES core: streams plaintext and key out as 32 bytes,
// then gathers the 16-byte ciphertext burst, with a response watchdog and an inter-frame gap.
module aes_serial_host #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int GAP_CYCLES     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] plain_text,
    input  logic [127:0] key,
    output logic         ser_enable,
    output logic [7:0]   ser_data,
    input  logic         ser_valid,
    input  logic [7:0]   ser_data_in,
    output logic [127:0] cipher_text,
    output logic         busy,
    output logic         done,
    output logic         error
);

    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_PT,
        SEND_KEY,
        WAIT_RESP,
        RECV,
        GAP
    } state_t;

    state_t           state;
    logic [127:0]     pt_sh;
    logic [127:0]     key_sh;
    logic [127:0]     rx_buf;
    logic [3:0]       tx_idx;
    logic [4:0]       rx_cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic [GAP_W-1:0] gap_cnt;

    // Byte 0 is the most significant byte of the word.
    function automatic logic [7:0] byte_of(input logic [127:0] w, input logic [3:0] idx);
        return w[8*(15 - int'(idx)) +: 8];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pt_sh       <= '0;
            key_sh      <= '0;
            rx_buf      <= '0;
            tx_idx      <= '0;
            rx_cnt      <= '0;
            wd_cnt      <= '0;
            gap_cnt     <= '0;
            ser_enable  <= 1'b0;
            ser_data    <= '0;
            cipher_text <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults here are overridden by later assignments in the case arms,
            // which is what turns done/error into single-cycle pulses.
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pt_sh      <= plain_text;
                        key_sh     <= key;
                        tx_idx     <= '0;
                        ser_enable <= 1'b1;
                        ser_data   <= plain_text[127:120];
                        busy       <= 1'b1;
                        state      <= SEND_PT;
                    end
                end
                SEND_PT: begin
                    if (tx_idx == 4'd15) begin
                        tx_idx   <= '0;
                        ser_data <= key_sh[127:120];
                        state    <= SEND_KEY;
                    end else begin
                        tx_idx   <= tx_idx + 4'd1;
                        ser_data <= byte_of(pt_sh, tx_idx + 4'd1);
                    end
                end
                SEND_KEY: begin
                    if (tx_idx == 4'd15) begin
                        ser_enable <= 1'b0;
                        ser_data   <= '0;
                        wd_cnt     <= '0;
                        state      <= WAIT_RESP;
                    end else begin
                        tx_idx   <= tx_idx + 4'd1;
                        ser_data <= byte_of(key_sh, tx_idx + 4'd1);
                    end
                end
                WAIT_RESP: begin
                    if (ser_valid) begin
                        rx_buf[127:120] <= ser_data_in;
                        rx_cnt          <= 5'd1;
                        state           <= RECV;
                    end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        error   <= 1'b1;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                RECV: begin
                    // The full word is published one edge after the 16th byte lands.
                    if (rx_cnt == 5'd16) begin
                        cipher_text <= rx_buf;
                        done        <= 1'b1;
                        gap_cnt     <= '0;
                        state       <= GAP;
                    end else if (ser_valid) begin
                        rx_buf[8*(15 - int'(rx_cnt[3:0])) +: 8] <= ser_data_in;
                        rx_cnt <= rx_cnt + 5'd1;
                    end else begin
                        error   <= 1'b1;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_serial_host.sv
// Scoreboard bench for aes_serial_host: stimulus pushes expected bytes/results, a monitor pops them
// as the DUT presents serial bytes and done/error pulses; a behavioural responder plays the AES core.
module tb_aes_serial_host;

    localparam int TIMEOUT = 16;
    localparam int GAPC    = 2;

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] ORD_PT   = 128'h0102030405060708090a0b0c0d0e0f10;
    localparam logic [127:0] ORD_KEY  = 128'h1112131415161718191a1b1c1d1e1f20;
    localparam logic [127:0] ORD_CT   = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    typedef enum int {R_NORMAL, R_SILENT, R_SHORT} resp_mode_t;
    typedef struct packed {
        logic         is_err;
        logic [127:0] ct;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] plain_text;
    logic [127:0] key;
    logic         ser_enable;
    logic [7:0]   ser_data;
    logic         ser_valid;
    logic [7:0]   ser_data_in;
    logic [127:0] cipher_text;
    logic         busy;
    logic         done;
    logic         error;

    always #5 clk = ~clk;

    aes_serial_host #(.TIMEOUT_CYCLES(TIMEOUT), .GAP_CYCLES(GAPC)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .plain_text (plain_text),
        .key        (key),
        .ser_enable (ser_enable),
        .ser_data   (ser_data),
        .ser_valid  (ser_valid),
        .ser_data_in(ser_data_in),
        .cipher_text(cipher_text),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    logic [7:0]   exp_bytes[$];
    res_t         exp_res[$];
    int           total = 0;
    int           bad = 0;
    int           pulse_cnt = 0;
    int           done_cnt = 0;
    int           last_low = 0;
    int           frames = 0;
    resp_mode_t   resp_mode = R_NORMAL;
    logic [127:0] resp_ct = '0;
    logic [127:0] last_ct = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares serial bytes, frame length and result pulses against the queues.
    initial begin : monitor
        int   run_len = 0;
        int   low_run = 0;
        bit   in_abort = 1'b0;
        bit   seen_frame = 1'b0;
        bit   prev_done = 1'b0;
        bit   prev_err = 1'b0;
        logic [7:0] eb;
        res_t er;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_abort   = 1'b1;
                run_len    = 0;
                low_run    = 0;
                seen_frame = 1'b0;
                prev_done  = 1'b0;
                prev_err   = 1'b0;
            end else begin
                if (ser_enable) begin
                    if (run_len == 0 && seen_frame) last_low = low_run;
                    low_run = 0;
                    if (!in_abort) begin
                        if (exp_bytes.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL ser_data: got %h while no byte was expected", ser_data);
                        end else begin
                            eb = exp_bytes.pop_front();
                            check("ser_data", ser_data, eb);
                        end
                    end
                    run_len++;
                end else begin
                    if (run_len != 0 && !in_abort) check("frame length", run_len, 32);
                    if (run_len != 0) seen_frame = 1'b1;
                    run_len  = 0;
                    in_abort = 1'b0;
                    low_run++;
                end
                if (done && error) begin
                    total++;
                    bad++;
                    $display("FAIL pulse exclusive: done=1 error=1 required one of them");
                end
                if ((done && prev_done) || (error && prev_err)) begin
                    total++;
                    bad++;
                    $display("FAIL pulse width: pulse high for 2+ cycles, required 1");
                end
                if (done || error) begin
                    pulse_cnt++;
                    if (done) done_cnt++;
                    check("busy on pulse", busy, 1);
                    if (exp_res.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL result: got done=%0b error=%0b with no result expected", done, error);
                    end else begin
                        er = exp_res.pop_front();
                        check("result is error", error, er.is_err);
                        check("cipher_text", cipher_text, er.ct);
                    end
                end
                prev_done = done;
                prev_err  = error;
            end
        end
    end

    // Responder: after a 32-byte frame, returns resp_ct (all, none, or 10 bytes).
    initial begin : responder
        int rx_seen = 0;
        int nbytes;
        ser_valid   = 1'b0;
        ser_data_in = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rx_seen = 0;
            end else if (ser_enable) begin
                rx_seen++;
            end else if (rx_seen == 32) begin
                rx_seen = 0;
                nbytes = (resp_mode == R_NORMAL) ? 16 : (resp_mode == R_SHORT) ? 10 : 0;
                repeat (2) @(posedge clk);
                for (int i = 0; i < nbytes; i++) begin
                    @(posedge clk);
                    #1;
                    ser_valid   = 1'b1;
                    ser_data_in = resp_ct[8*(15-i) +: 8];
                end
                @(posedge clk);
                #1;
                ser_valid   = 1'b0;
                ser_data_in = '0;
            end else begin
                rx_seen = 0;
            end
        end
    end

    task automatic push_frame(input logic [127:0] pt, input logic [127:0] k);
        for (int i = 0; i < 16; i++) exp_bytes.push_back(pt[8*(15-i) +: 8]);
        for (int i = 0; i < 16; i++) exp_bytes.push_back(k[8*(15-i) +: 8]);
    endtask

    task automatic push_result(input logic is_err, input logic [127:0] ct);
        res_t r;
        r.is_err = is_err;
        r.ct     = is_err ? last_ct : ct;
        exp_res.push_back(r);
        if (!is_err) last_ct = ct;
        frames++;
    endtask

    // Issues one start pulse, then scrambles the inputs to prove the shadow registers hold them.
    task automatic start_frame(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] ct,
                               input resp_mode_t mode, input logic is_err);
        push_frame(pt, k);
        push_result(is_err, ct);
        resp_mode = mode;
        resp_ct   = ct;
        @(posedge clk);
        #1;
        start      = 1'b1;
        plain_text = pt;
        key        = k;
        @(posedge clk);
        #1;
        start      = 1'b0;
        plain_text = ~pt;
        key        = ~k;
        @(negedge clk);
        check("enable one edge after start", ser_enable, 1);
    endtask

    task automatic finish_frame();
        int n = 0;
        while (pulse_cnt < frames && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("result pulse arrived", pulse_cnt >= frames, 1);
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("back to idle", busy, 0);
    endtask

    initial begin : global_timeout
        #500000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int n;
        int base;
        rst        = 1'b1;
        start      = 1'b0;
        plain_text = '0;
        key        = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset ser_enable", ser_enable, 0);
        check("reset ser_data", ser_data, 0);
        check("reset cipher_text", cipher_text, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset error", error, 0);

        // FIPS-197 vector
        start_frame(FIPS_PT, FIPS_KEY, FIPS_CT, R_NORMAL, 1'b0);
        finish_frame();

        // byte order
        start_frame(ORD_PT, ORD_KEY, ORD_CT, R_NORMAL, 1'b0);
        finish_frame();

        // timeout: silent responder
        start_frame(FIPS_PT, FIPS_KEY, FIPS_CT, R_SILENT, 1'b1);
        n = 0;
        while (ser_enable && n < 64) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!error && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("timeout latency", n, TIMEOUT);
        n = 0;
        while (busy && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("error to idle cycles", n, GAPC);
        check("cipher_text kept after timeout", cipher_text, ORD_CT);
        finish_frame();

        // short frame
        start_frame(ORD_PT, ORD_KEY, FIPS_CT, R_SHORT, 1'b1);
        finish_frame();
        check("cipher_text kept after short frame", cipher_text, ORD_CT);

        // start pulses during SEND_KEY and RECV are ignored
        start_frame(FIPS_PT, FIPS_KEY, FIPS_CT, R_NORMAL, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!ser_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_frame();

        // start held high: two back-to-back frames
        base = done_cnt;
        push_frame(ORD_PT, ORD_KEY);
        push_result(1'b0, FIPS_CT);
        push_frame(ORD_PT, ORD_KEY);
        push_result(1'b0, FIPS_CT);
        resp_mode = R_NORMAL;
        resp_ct   = FIPS_CT;
        @(posedge clk);
        #1;
        start      = 1'b1;
        plain_text = ORD_PT;
        key        = ORD_KEY;
        n = 0;
        while (pulse_cnt < frames - 1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("first held frame result", pulse_cnt >= frames - 1, 1);
        n = 0;
        while (!ser_enable && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("second held frame started", ser_enable, 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_frame();
        check("two done pulses", done_cnt - base, 2);
        check("inter-frame gap", last_low >= GAPC, 1);

        // reset on key byte 7
        start_frame(FIPS_PT, FIPS_KEY, FIPS_CT, R_NORMAL, 1'b0);
        repeat (22) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_bytes.delete();
        exp_res.delete();
        frames--;
        last_ct = '0;
        @(negedge clk);
        check("abort ser_enable", ser_enable, 0);
        check("abort busy", busy, 0);
        check("abort cipher_text", cipher_text, 0);
        base = pulse_cnt;
        repeat (40) @(negedge clk);
        check("no pulse after abort", pulse_cnt, base);
        start_frame(FIPS_PT, FIPS_KEY, FIPS_CT, R_NORMAL, 1'b0);
        finish_frame();
        check("final cipher_text", cipher_text, FIPS_CT);

        repeat (5) @(negedge clk);
        check("leftover bytes", exp_bytes.size(), 0);
        check("leftover results", exp_res.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
